// File: rtl/rangefinder_pkg.sv
// Shared types and default sizing for the rangefinder session sequencer.
package rangefinder_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  // The range field is sized by the package width, so the top's WIDTH must match it.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] range;
    logic                 error;
    logic                 timeout;
  } result_t;

endpackage

// File: rtl/rangefinder_sequencer_stall_timer.sv
// Saturating stall counter: counts enabled cycles, clears on demand, flags TIMEOUT.
module rangefinder_sequencer_stall_timer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stops at LIMIT rather than wrapping, so expired stays high until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/rangefinder_sequencer.sv
// Session controller for the rangefinder: streams a burst into go/finish/data_in
// and presents the captured range and status on a result handshake.
module rangefinder_sequencer
  import rangefinder_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             rf_go,
  output logic             rf_finish,
  output logic [WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_range,
  output logic             res_error,
  output logic             res_timeout,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             tflag_q, tflag_d;
  result_t          res_q, res_d;

  logic accept;
  logic last_accept;
  logic expired;
  logic abort;
  logic timer_clr;
  logic timer_en;

  assign accept      = in_valid && (state_q == RUN);
  assign last_accept = accept && (sample_cnt_q == (len_q - CNT_W'(1)));
  // Accept has priority over an expired stall counter in the same cycle.
  assign abort       = (state_q == RUN) && expired && !accept;
  assign timer_en    = (state_q == RUN) && !accept;

  rangefinder_sequencer_stall_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    last_d       = last_q;
    tflag_d      = tflag_q;
    res_d        = res_q;
    timer_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sample_cnt_d = '0;
          if (burst_len != '0) begin
            len_d     = burst_len;
            tflag_d   = 1'b0;
            timer_clr = 1'b1;
            state_d   = RUN;
          end else begin
            res_d   = '{range: '0, error: 1'b1, timeout: 1'b0};
            state_d = HOLD;
          end
        end
      end
      RUN: begin
        if (accept) begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          last_d       = in_data;
          timer_clr    = 1'b1;
          if (last_accept) begin
            state_d = WAIT;
          end
        end else if (expired) begin
          if (sample_cnt_q != '0) begin
            tflag_d = 1'b1;
            state_d = WAIT;
          end else begin
            res_d   = '{range: '0, error: 1'b0, timeout: 1'b1};
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        res_d   = '{range: rf_range, error: rf_error, timeout: tflag_q};
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      sample_cnt_q <= '0;
      last_q       <= '0;
      tflag_q      <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      last_q       <= last_d;
      tflag_q      <= tflag_d;
      res_q        <= res_d;
    end
  end

  // A timeout with samples in flight closes the session by replaying the last sample.
  assign in_ready    = (state_q == RUN);
  assign rf_go       = accept && (sample_cnt_q == '0);
  assign rf_finish   = last_accept || (abort && (sample_cnt_q != '0));
  assign rf_data     = accept ? in_data : last_q;
  assign res_valid   = (state_q == HOLD);
  assign res_range   = res_q.range;
  assign res_error   = res_q.error;
  assign res_timeout = res_q.timeout;
  assign busy        = (state_q != IDLE);
  assign sample_cnt  = sample_cnt_q;

endmodule
